// File: rtl/count_sweep_ctrl_if.sv
// Bundle of the sweep controller's host-side controls and counter-side
// signals. The master side (host plus counter) drives the requests and the
// counter value. The slave side (the sequencer) drives the counter controls
// and the status flags.
interface count_sweep_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
);
    // host requests
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PASS_W-1:0] passes;
    // counter feedback
    logic [WIDTH-1:0]  cnt;
    // counter controls
    logic              load;
    logic [WIDTH-1:0]  vf;
    logic              dir;
    // status
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, lo, hi, passes, cnt,
        input  load, vf, dir, busy, done, err
    );

    modport slave (
        input  start, abort, lo, hi, passes, cnt,
        output load, vf, dir, busy, done, err
    );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Ping-pong sweep sequencer for a bidirectional counter with parallel load.
// The counter is driven lo -> hi -> lo for a programmed number of passes.
// Its returned value is compared every sweep cycle with an internal
// expected count. While no sweep runs, the counter is frozen by continuous
// load of the expected count. Every counter control and status output
// comes from a register.
module count_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    count_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] ZERO_P = {PASS_W{1'b0}};
    localparam logic [PASS_W-1:0] ONE_P  = {{(PASS_W-1){1'b0}}, 1'b1};

    // An empty or inverted window cannot be swept.
    function automatic logic cfg_bad(input logic [WIDTH-1:0] lo_v,
                                     input logic [WIDTH-1:0] hi_v);
        return (hi_v <= lo_v);
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [PASS_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              load_q, load_d;
    logic [WIDTH-1:0]  vf_q, vf_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;

    logic              mismatch_s;
    logic              at_top_s;
    logic              at_bottom_s;
    logic              last_pass_s;

    // The counter should hold exactly the expected count in every sweep cycle.
    assign mismatch_s  = (bus.cnt != exp_q);
    // Turn-around points: the edge where the counter reaches hi or lo.
    assign at_top_s    = (exp_q == (hi_q - ONE_W));
    assign at_bottom_s = (exp_q == (lo_q + ONE_W));
    assign last_pass_s = (pc_q == ONE_P);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered-output register bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q    <= ZERO_W;
            lo_q     <= ZERO_W;
            hi_q     <= ZERO_W;
            passes_q <= ZERO_P;
            pc_q     <= ZERO_P;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b1;
            vf_q     <= ZERO_W;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            passes_q <= passes_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            done_q   <= done_d;
            load_q   <= load_d;
            vf_q     <= vf_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, expected-count tracking, pass counting and error capture.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        passes_d = passes_q;
        pc_d     = pc_q;
        err_d    = err_q;
        done_d   = 1'b0;

        if (bus.abort) begin
            // Abort overrides everything. The expected count is kept so the
            // counter freezes where it stopped. err is left untouched.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        lo_d     = bus.lo;
                        hi_d     = bus.hi;
                        passes_d = bus.passes;
                        err_d    = 1'b0;
                        if (cfg_bad(bus.lo, bus.hi)) begin
                            err_d = 1'b1;
                        end else if (bus.passes == ZERO_P) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_UP;
                    exp_d   = lo_q;
                    pc_d    = passes_q;
                end
                ST_UP: begin
                    if (mismatch_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        exp_d = exp_q + ONE_W;
                        if (at_top_s) begin
                            state_d = ST_DOWN;
                        end else begin
                            state_d = ST_UP;
                        end
                    end
                end
                ST_DOWN: begin
                    if (mismatch_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        exp_d = exp_q - ONE_W;
                        if (at_bottom_s) begin
                            pc_d = pc_q - ONE_P;
                            if (last_pass_s) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                                exp_d   = lo_q;
                            end else begin
                                state_d = ST_UP;
                            end
                        end else begin
                            state_d = ST_DOWN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Counter controls decoded from the upcoming state, so each output is a register.
    always_comb begin
        load_d = 1'b1;
        vf_d   = exp_d;
        dir_d  = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                load_d = 1'b1;
                vf_d   = exp_d;
            end
            ST_LOAD: begin
                load_d = 1'b1;
                vf_d   = lo_d;
                busy_d = 1'b1;
            end
            ST_UP: begin
                load_d = 1'b0;
                dir_d  = 1'b0;
                busy_d = 1'b1;
            end
            ST_DOWN: begin
                load_d = 1'b0;
                dir_d  = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                load_d = 1'b1;
                vf_d   = exp_d;
            end
        endcase
    end

    assign bus.load = load_q;
    assign bus.vf   = vf_q;
    assign bus.dir  = dir_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Self-checking bench for count_sweep_ctrl. A behavioural 4-bit up/down
// counter with parallel load closes the loop. Each sweep pushes its expected
// counter trajectory into a queue. The queue is popped on every UP/DOWN cycle.
module tb_count_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_sweep_ctrl_if #(.WIDTH(4), .PASS_W(4)) bus ();

    count_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural counter, with an override used to inject a wrong value.
    logic [3:0] cnt_model;
    logic       force_en;
    logic [3:0] force_val;
    assign bus.cnt = force_en ? force_val : cnt_model;

    always @(posedge clk) begin
        if (bus.load)     cnt_model <= bus.vf;
        else if (bus.dir) cnt_model <= cnt_model - 4'd1;
        else              cnt_model <= cnt_model + 4'd1;
    end

    typedef struct packed {
        logic [3:0] cnt;
        logic       dir;
    } exp_t;
    exp_t sb_q[$];

    // kind: 0 = full sweep, 1 = rejected config, 2 = zero passes
    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] p;
        int         kind;
    } vec_t;
    vec_t vecs[7];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a start pulse and queue the ping-pong trajectory for a valid config.
    task automatic drive_start(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] p);
        bus.lo     = lo;
        bus.hi     = hi;
        bus.passes = p;
        bus.start  = 1'b1;
        if (hi > lo && p != 4'd0) begin
            for (int ps = 0; ps < int'(p); ps++) begin
                for (int v = int'(lo); v < int'(hi); v++) sb_q.push_back({v[3:0], 1'b0});
                for (int v = int'(hi); v > int'(lo); v--) sb_q.push_back({v[3:0], 1'b1});
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Follow a sweep from its LOAD cycle until done or until an abort is injected.
    task automatic track(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] p,
                         input bit inject, input int abort_val);
        int   k;
        bit   fin;
        bit   aborted;
        int   exp_len;
        exp_t e;
        exp_len = 1 + 2 * int'(p) * (int'(hi) - int'(lo));
        chk("load_cycle", {31'd0, bus.busy & bus.load}, 32'd1);
        k = 0; fin = 1'b0; aborted = 1'b0;
        while (!fin && k < 200) begin
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.done) begin
                fin = 1'b1;
            end else if (bus.busy && !bus.load) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sb_underflow: got cnt %0d with nothing expected", bus.cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk("sweep_cnt", {28'd0, bus.cnt}, {28'd0, e.cnt});
                    chk("sweep_dir", {31'd0, bus.dir}, {31'd0, e.dir});
                end
                if (inject && k == 2) begin
                    bus.lo = 4'd0; bus.hi = 4'd9; bus.passes = 4'd5; bus.start = 1'b1;
                end
                if (bus.dir && int'(bus.cnt) == abort_val) begin
                    bus.abort = 1'b1;
                    fin = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        if (!fin) begin
            n_vec++; n_bad++;
            $display("FAIL sweep_timeout: got no done after %0d cycles, expected %0d", k, exp_len);
        end else if (aborted) begin
            @(negedge clk);
            bus.abort = 1'b0;
            chk("abort_busy", {31'd0, bus.busy}, 32'd0);
            chk("abort_load", {31'd0, bus.load}, 32'd1);
            chk("abort_vf",   {28'd0, bus.vf}, abort_val);
            chk("abort_done", {31'd0, bus.done}, 32'd0);
            chk("abort_err",  {31'd0, bus.err}, 32'd0);
            sb_q.delete();
            @(negedge clk);
            chk("abort_nodone", {31'd0, bus.done}, 32'd0);
            chk("abort_hold",   {28'd0, bus.cnt}, abort_val);
        end else begin
            chk("sweep_len",  k, exp_len);
            chk("done_cnt",   {28'd0, bus.cnt}, {28'd0, lo});
            chk("done_vf",    {28'd0, bus.vf}, {28'd0, lo});
            chk("done_load",  {31'd0, bus.load}, 32'd1);
            chk("done_busy",  {31'd0, bus.busy}, 32'd0);
            chk("done_err",   {31'd0, bus.err}, 32'd0);
            chk("sb_left",    sb_q.size(), 32'd0);
            sb_q.delete();
            @(negedge clk);
            chk("done_pulse", {31'd0, bus.done}, 32'd0);
            chk("hold_cnt",   {28'd0, bus.cnt}, {28'd0, lo});
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{lo: 4'd2,  hi: 4'd5,  p: 4'd1, kind: 0};
        vecs[1] = '{lo: 4'd0,  hi: 4'd1,  p: 4'd3, kind: 0};
        vecs[2] = '{lo: 4'd7,  hi: 4'd7,  p: 4'd1, kind: 1};
        vecs[3] = '{lo: 4'd9,  hi: 4'd3,  p: 4'd2, kind: 1};
        vecs[4] = '{lo: 4'd3,  hi: 4'd6,  p: 4'd0, kind: 2};
        vecs[5] = '{lo: 4'd14, hi: 4'd15, p: 4'd2, kind: 0};
        vecs[6] = '{lo: 4'd0,  hi: 4'd15, p: 4'd1, kind: 0};

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.lo = 4'd0; bus.hi = 4'd0; bus.passes = 4'd0;
        force_en = 1'b0; force_val = 4'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_load", {31'd0, bus.load}, 32'd1);
        chk("rst_vf",   {28'd0, bus.vf}, 32'd0);
        chk("rst_dir",  {31'd0, bus.dir}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err",  {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven sweeps and configuration corner cases.
        for (int i = 0; i < 7; i++) begin
            drive_start(vecs[i].lo, vecs[i].hi, vecs[i].p);
            case (vecs[i].kind)
                0: track(vecs[i].lo, vecs[i].hi, vecs[i].p, 1'b0, -1);
                1: begin
                    chk("badcfg_err",  {31'd0, bus.err}, 32'd1);
                    chk("badcfg_busy", {31'd0, bus.busy}, 32'd0);
                    chk("badcfg_done", {31'd0, bus.done}, 32'd0);
                    @(negedge clk);
                    chk("badcfg_idle", {31'd0, bus.busy}, 32'd0);
                    chk("badcfg_sticky", {31'd0, bus.err}, 32'd1);
                end
                2: begin
                    chk("zero_done", {31'd0, bus.done}, 32'd1);
                    chk("zero_err",  {31'd0, bus.err}, 32'd0);
                    chk("zero_busy", {31'd0, bus.busy}, 32'd0);
                    @(negedge clk);
                    chk("zero_pulse", {31'd0, bus.done}, 32'd0);
                end
                default: begin
                    n_vec++; n_bad++;
                    $display("FAIL vec_kind: got %0d", vecs[i].kind);
                end
            endcase
        end

        // Wrong counter value during UP: the sweep stops and freezes at the expected count.
        drive_start(4'd2, 4'd6, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.busy && !bus.load && !bus.dir && bus.cnt == 4'd3) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            n_vec++; n_bad++;
            $display("FAIL mism_timeout: got no UP cycle with cnt 3");
        end
        force_en = 1'b1; force_val = 4'd4;
        @(negedge clk);
        force_en = 1'b0;
        chk("mism_err",  {31'd0, bus.err}, 32'd1);
        chk("mism_busy", {31'd0, bus.busy}, 32'd0);
        chk("mism_load", {31'd0, bus.load}, 32'd1);
        chk("mism_vf",   {28'd0, bus.vf}, 32'd3);
        chk("mism_done", {31'd0, bus.done}, 32'd0);
        sb_q.delete();
        @(negedge clk);

        // A good start clears the sticky error.
        drive_start(4'd2, 4'd5, 4'd1);
        chk("err_cleared", {31'd0, bus.err}, 32'd0);
        track(4'd2, 4'd5, 4'd1, 1'b0, -1);

        // Start ignored while busy, then abort in DOWN at count 4.
        drive_start(4'd2, 4'd6, 4'd1);
        track(4'd2, 4'd6, 4'd1, 1'b1, 4);

        // Reset in the middle of UP.
        drive_start(4'd2, 4'd6, 4'd2);
        repeat (2) @(negedge clk);
        chk("midrst_up", {31'd0, bus.busy & ~bus.load & ~bus.dir}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_load", {31'd0, bus.load}, 32'd1);
        chk("midrst_vf",   {28'd0, bus.vf}, 32'd0);
        chk("midrst_dir",  {31'd0, bus.dir}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_err",  {31'd0, bus.err}, 32'd0);
        sb_q.delete();
        @(negedge clk);

        // Normal operation resumes after the reset.
        drive_start(4'd0, 4'd1, 4'd3);
        track(4'd0, 4'd1, 4'd3, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
